// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the block-transfer DMA engine.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_CAP,
    S_WR,
    S_REL,
    S_FIN
  } dma_state_e;

  localparam logic [1:0] CFG_SRC  = 2'd0;
  localparam logic [1:0] CFG_DST  = 2'd1;
  localparam logic [1:0] CFG_CNT  = 2'd2;
  localparam logic [1:0] CFG_CTRL = 2'd3;

  localparam int CTRL_START_BIT = 0;

endpackage

// File: rtl/dma_if.sv
// rtl/dma_if.sv - register port, HOLD/HLDA handshake and RAM port of the DMA engine.
interface dma_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cfg_wr;
  logic [1:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              busy;
  logic              done;
  logic              hold;
  logic              hlda;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cfg_wr, cfg_addr, cfg_wdata, hlda, mem_rdata,
    output busy, done, hold, mem_en, mem_rw, mem_addr, mem_wdata
  );

  modport slave (
    output cfg_wr, cfg_addr, cfg_wdata, hlda, mem_rdata,
    input  busy, done, hold, mem_en, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dma_regs.sv
// rtl/dma_regs.sv - cfg-port decode and the SRC/DST/COUNT registers.
module dma_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cfg_wr,
  input  logic [1:0]        i_cfg_addr,
  input  logic [DATA_W-1:0] i_cfg_wdata,
  input  logic              i_idle,
  input  logic              i_step,
  output logic              o_start,
  output logic [ADDR_W-1:0] o_src,
  output logic [ADDR_W-1:0] o_dst,
  output logic [ADDR_W-1:0] o_count
);
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_count;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_load;

  // Every cfg write, CTRL included, is dropped while a transfer is in flight.
  assign w_wr_en = i_cfg_wr && i_idle;
  assign w_load  = ADDR_W'(i_cfg_wdata);
  assign o_start = w_wr_en && (i_cfg_addr == CFG_CTRL) && i_cfg_wdata[CTRL_START_BIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en && (i_cfg_addr == CFG_SRC)) r_src <= w_load;
      else if (i_step)                        r_src <= r_src + ADDR_W'(1);

      if (w_wr_en && (i_cfg_addr == CFG_DST)) r_dst <= w_load;
      else if (i_step)                        r_dst <= r_dst + ADDR_W'(1);

      if (w_wr_en && (i_cfg_addr == CFG_CNT)) r_count <= w_load;
      else if (i_step)                        r_count <= r_count - ADDR_W'(1);
    end
  end

  assign o_src   = r_src;
  assign o_dst   = r_dst;
  assign o_count = r_count;
endmodule

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - HOLD/HLDA block-copy DMA FSM; DMA_BURST_LIMIT_EN releases the bus every BURST_LEN bytes.
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input logic   clk,
  input logic   reset,
  dma_if.master bus
);
`ifdef DMA_BURST_LIMIT_EN
  localparam bit BURST_LIMIT = 1'b1;
`else
  localparam bit BURST_LIMIT = 1'b0;
`endif
  localparam int BURST_W = $clog2(BURST_LEN + 1);

  dma_state_e        r_state;
  dma_state_e        w_next;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic [BURST_W-1:0] r_burst;

  logic              w_start;
  logic              w_idle;
  logic              w_step;
  logic              w_last;
  logic              w_burst_hit;
  logic [ADDR_W-1:0] w_src;
  logic [ADDR_W-1:0] w_dst;
  logic [ADDR_W-1:0] w_count;

  logic              w_hold;
  logic              w_en;
  logic              w_rw;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  dma_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regs (
    .clk         (clk),
    .reset       (reset),
    .i_cfg_wr    (bus.cfg_wr),
    .i_cfg_addr  (bus.cfg_addr),
    .i_cfg_wdata (bus.cfg_wdata),
    .i_idle      (w_idle),
    .i_step      (w_step),
    .o_start     (w_start),
    .o_src       (w_src),
    .o_dst       (w_dst),
    .o_count     (w_count)
  );

  assign w_idle      = (r_state == S_IDLE);
  assign w_step      = (r_state == S_WR);
  assign w_last      = (w_count == ADDR_W'(1));
  assign w_burst_hit = BURST_LIMIT && (r_burst == BURST_W'(BURST_LEN - 1));

  always_comb begin
    w_next  = r_state;
    w_hold  = 1'b0;
    w_en    = 1'b0;
    w_rw    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      S_IDLE: if (w_start) w_next = (w_count != '0) ? S_REQ : S_FIN;
      S_REQ: begin
        w_hold = 1'b1;
        if (bus.hlda) w_next = S_RD;
      end
      S_RD: begin
        w_hold = 1'b1;
        w_en   = 1'b1;
        w_addr = w_src;
        w_next = S_CAP;
      end
      S_CAP: begin
        w_hold = 1'b1;
        w_next = S_WR;
      end
      S_WR: begin
        w_hold  = 1'b1;
        w_en    = 1'b1;
        w_rw    = 1'b1;
        w_addr  = w_dst;
        w_wdata = r_data;
        if (w_last)           w_next = S_FIN;
        else if (w_burst_hit) w_next = S_REL;
        else                  w_next = S_RD;
      end
      S_REL:   if (!bus.hlda) w_next = S_REQ;
      S_FIN:   if (!bus.hlda) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_burst <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_FIN) && !bus.hlda;
      if (r_state == S_CAP) r_data <= bus.mem_rdata;
      // The tenure counter restarts each time the bus is re-requested.
      if ((r_state != S_REQ) && (w_next == S_REQ)) r_burst <= '0;
      else if (r_state == S_WR)                    r_burst <= r_burst + BURST_W'(1);
    end
  end

  assign bus.busy      = !w_idle;
  assign bus.done      = r_done;
  assign bus.hold      = w_hold;
  assign bus.mem_en    = w_en;
  assign bus.mem_rw    = w_rw;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;
endmodule

// File: tb/tb_dma_controller.sv
// tb/tb_dma_controller.sv - self-checking bench for dma_controller with RAM and CPU bus-grant models.
module tb_dma_controller;
  import dma_pkg::*;

  localparam int BL = 4;
`ifdef DMA_BURST_LIMIT_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   lat_max = 0;
  int   gnt_wait = 0;
  int   last_t = 0;
  logic fill_req = 1'b0;

  logic [7:0] ram     [256];
  logic [7:0] exp_ram [256];
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];
  int         rd_cyc_q[$];
  int         wr_cyc_q[$];
  int   done_cnt = 0, done_cyc = 0, busy_cnt = 0, hold_rise = 0;
  int   idle_bus_err = 0, hold_err = 0;
  logic hold_prev = 1'b0;

  dma_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dma_controller #(.ADDR_W(8), .DATA_W(8), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: synchronous write, read data valid the cycle after the read; garbage otherwise.
  always @(posedge clk) begin
    if (fill_req) for (int i = 0; i < 256; i++) ram[i] <= 8'($urandom);
    else if (bus.mem_en && bus.mem_rw) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= (bus.mem_en && !bus.mem_rw) ? ram[bus.mem_addr] : 8'($urandom);
  end

  // CPU: grants hold after a random latency, drops hlda the cycle after hold falls.
  always @(posedge clk) begin
    if (reset) begin
      bus.hlda <= 1'b0;
      gnt_wait <= 0;
    end else if (!bus.hold) begin
      bus.hlda <= 1'b0;
      gnt_wait <= int'($urandom_range(lat_max, 0));
    end else if (!bus.hlda) begin
      if (gnt_wait == 0) bus.hlda <= 1'b1;
      else gnt_wait <= gnt_wait - 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_en && !bus.mem_rw) begin rd_q.push_back(bus.mem_addr); rd_cyc_q.push_back(cyc); end
      if (bus.mem_en && bus.mem_rw)  begin wr_q.push_back(bus.mem_addr); wr_cyc_q.push_back(cyc); end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.busy) busy_cnt++;
      if (bus.hold && !hold_prev) hold_rise++;
      if (!bus.mem_en && (bus.mem_addr != 8'h00 || bus.mem_wdata != 8'h00)) idle_bus_err++;
      if (bus.mem_en && !bus.hold) hold_err++;
    end
    hold_prev = bus.hold;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    tick();
    bus.cfg_wr    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    last_t        = cyc;
    tick();
    bus.cfg_wr    = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    cfg_write(CFG_SRC, s);
    cfg_write(CFG_DST, d);
    cfg_write(CFG_CNT, n);
    cfg_write(CFG_CTRL, 8'h01);
  endtask

  task automatic fill_ram();
    tick();
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    for (int i = 0; i < 256; i++) exp_ram[i] = ram[i];
  endtask

  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) exp_ram[8'(d + i)] = exp_ram[8'(s + i)];
  endtask

  task automatic wait_done(input int d0, output bit ok);
    int n = 0;
    while (done_cnt == d0 && n < 600) begin tick(); n++; end
    ok = (done_cnt != d0);
  endtask

  function automatic int ram_diffs();
    int d = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) d++;
    return d;
  endfunction

  function automatic int seq_diffs(input bit is_wr, input int start, input logic [7:0] base, input int n);
    int d = 0;
    int sz = is_wr ? wr_q.size() : rd_q.size();
    if (sz - start != n) return 1000 + sz - start;
    for (int i = 0; i < n; i++)
      if ((is_wr ? wr_q[start + i] : rd_q[start + i]) !== 8'(base + i)) d++;
    return d;
  endfunction

  function automatic int exp_tenures(input int n);
    return BURST_ON ? (n + BL - 1) / BL : 1;
  endfunction

  task automatic test_reset();
    logic [20:0] v;
    v = {bus.busy, bus.hold, bus.done, bus.mem_en, bus.mem_rw, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (v !== 21'h0) $display("FAIL reset_outputs: got %h want 0", v);
    if (v !== 21'h0) errors++;
  endtask

  task automatic test_basic();
    int r0, w0, d0, b0, t;
    bit ok;
    lat_max = 0;
    fill_ram();
    r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt; b0 = busy_cnt;
    start_xfer(8'h10, 8'h40, 8'd3);
    t = last_t;
    checks++;
    if ({bus.busy, bus.hold} !== 2'b11) begin errors++; $display("FAIL basic_start: busy,hold=%b want 11", {bus.busy, bus.hold}); end
    model_copy(8'h10, 8'h40, 3);
    wait_done(d0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: no done"); end
    checks++;
    if (done_cyc !== t + 14) begin errors++; $display("FAIL basic_done_cycle: got t+%0d want t+14", done_cyc - t); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", bus.busy); end
    repeat (4) tick();
    checks++;
    if (busy_cnt - b0 !== 13) begin errors++; $display("FAIL basic_busy_span: got %0d want 13", busy_cnt - b0); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    checks++;
    if (rd_cyc_q[r0] !== t + 3 || wr_cyc_q[w0 + 2] - rd_cyc_q[r0] + 1 !== 9)
      begin errors++; $display("FAIL basic_mem_window: first RD t+%0d want t+3, span %0d want 9",
                               rd_cyc_q[r0] - t, wr_cyc_q[w0 + 2] - rd_cyc_q[r0] + 1); end
    checks++;
    if (seq_diffs(0, r0, 8'h10, 3) !== 0 || seq_diffs(1, w0, 8'h40, 3) !== 0)
      begin errors++; $display("FAIL basic_addr_seq: rd=%0d wr=%0d want 0", seq_diffs(0, r0, 8'h10, 3), seq_diffs(1, w0, 8'h40, 3)); end
    checks++;
    if (ram_diffs() !== 0) begin errors++; $display("FAIL basic_ram: diffs=%0d want 0", ram_diffs()); end
  endtask

  task automatic test_zero_count();
    int h0, t;
    h0 = hold_rise;
    fill_ram();
    start_xfer(8'h33, 8'h77, 8'd0);
    t = last_t;
    checks++;
    if ({bus.busy, bus.hold, bus.done} !== 3'b100) begin errors++; $display("FAIL zero_t1: busy,hold,done=%b want 100", {bus.busy, bus.hold, bus.done}); end
    tick();
    checks++;
    if ({bus.busy, bus.done} !== 2'b01 || cyc !== t + 2) begin errors++; $display("FAIL zero_t2: busy,done=%b want 01", {bus.busy, bus.done}); end
    repeat (4) tick();
    checks++;
    if (hold_rise !== h0 || ram_diffs() !== 0) begin errors++; $display("FAIL zero_no_bus: hold rises=%0d want 0, ram diffs=%0d", hold_rise - h0, ram_diffs()); end
  endtask

  task automatic test_wrap();
    int r0, w0, d0;
    bit ok;
    lat_max = 2;
    fill_ram();
    r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt;
    start_xfer(8'hFE, 8'h20, 8'd4);
    model_copy(8'hFE, 8'h20, 4);
    wait_done(d0, ok);
    repeat (3) tick();
    checks++;
    if (!ok || seq_diffs(0, r0, 8'hFE, 4) !== 0) begin errors++; $display("FAIL wrap_rd_seq: diffs=%0d want 0", seq_diffs(0, r0, 8'hFE, 4)); end
    checks++;
    if (seq_diffs(1, w0, 8'h20, 4) !== 0 || ram_diffs() !== 0)
      begin errors++; $display("FAIL wrap_wr: seq diffs=%0d ram diffs=%0d want 0", seq_diffs(1, w0, 8'h20, 4), ram_diffs()); end
  endtask

  task automatic test_reset_mid();
    int r0, w0, n;
    lat_max = 0;
    fill_ram();
    r0 = rd_q.size(); w0 = wr_q.size();
    start_xfer(8'h50, 8'h80, 8'd3);
    n = 0;
    while (rd_q.size() - r0 < 2 && n < 100) begin tick(); n++; end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.hold, bus.mem_en, bus.busy, bus.done} !== 4'b0000 || n >= 100)
      begin errors++; $display("FAIL reset_mid_outputs: hold,en,busy,done=%b want 0000", {bus.hold, bus.mem_en, bus.busy, bus.done}); end
    reset = 1'b0;
    repeat (4) tick();
    model_copy(8'h50, 8'h80, 1);
    checks++;
    if (wr_q.size() - w0 !== 1 || ram_diffs() !== 0)
      begin errors++; $display("FAIL reset_mid_partial: writes=%0d want 1, ram diffs=%0d", wr_q.size() - w0, ram_diffs()); end
  endtask

  task automatic test_burst();
    int h0, w0, d0;
    bit ok;
    lat_max = 2;
    fill_ram();
    h0 = hold_rise; w0 = wr_q.size(); d0 = done_cnt;
    start_xfer(8'h05, 8'h90, 8'd10);
    model_copy(8'h05, 8'h90, 10);
    wait_done(d0, ok);
    repeat (3) tick();
    checks++;
    if (!ok || hold_rise - h0 !== exp_tenures(10)) begin errors++; $display("FAIL burst_tenures: got %0d want %0d", hold_rise - h0, exp_tenures(10)); end
    checks++;
    if (seq_diffs(1, w0, 8'h90, 10) !== 0 || ram_diffs() !== 0) begin errors++; $display("FAIL burst_copy: ram diffs=%0d want 0", ram_diffs()); end
  endtask

  task automatic test_busy_ignore();
    int r0, d0;
    bit ok;
    lat_max = 1;
    fill_ram();
    r0 = rd_q.size(); d0 = done_cnt;
    start_xfer(8'h30, 8'h60, 8'd5);
    cfg_write(CFG_SRC, 8'h99);
    cfg_write(CFG_CTRL, 8'h01);
    model_copy(8'h30, 8'h60, 5);
    wait_done(d0, ok);
    repeat (10) tick();
    checks++;
    if (!ok || seq_diffs(0, r0, 8'h30, 5) !== 0) begin errors++; $display("FAIL ignore_src: rd seq diffs=%0d want 0", seq_diffs(0, r0, 8'h30, 5)); end
    checks++;
    if (done_cnt - d0 !== 1 || bus.busy !== 1'b0 || ram_diffs() !== 0)
      begin errors++; $display("FAIL ignore_ctrl: dones=%0d want 1, busy=%b, ram diffs=%0d", done_cnt - d0, bus.busy, ram_diffs()); end
  endtask

  task automatic test_random();
    logic [7:0] s, d, n;
    int r0, w0, d0, h0;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      lat_max = int'($urandom_range(3, 0));
      s = 8'($urandom);
      d = (it == 0) ? s + 8'd1 : 8'($urandom);
      n = 8'($urandom_range(12, 1));
      fill_ram();
      r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt; h0 = hold_rise;
      start_xfer(s, d, n);
      model_copy(s, d, int'(n));
      wait_done(d0, ok);
      repeat (3) tick();
      checks++;
      if (!ok || ram_diffs() !== 0 || seq_diffs(0, r0, s, int'(n)) !== 0 || seq_diffs(1, w0, d, int'(n)) !== 0)
        begin errors++; $display("FAIL random_%0d copy: src=%h dst=%h n=%0d ram diffs=%0d want 0", it, s, d, n, ram_diffs()); end
      checks++;
      if (done_cnt - d0 !== 1 || hold_rise - h0 !== exp_tenures(int'(n)))
        begin errors++; $display("FAIL random_%0d bus: dones=%0d want 1, tenures=%0d want %0d", it, done_cnt - d0, hold_rise - h0, exp_tenures(int'(n))); end
    end
  endtask

  initial begin
    bus.cfg_wr    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 8'h00;
    reset = 1'b1;
    repeat (3) tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_reset_mid();
    test_burst();
    test_busy_ignore();
    test_random();
    checks++;
    if (idle_bus_err !== 0 || hold_err !== 0)
      begin errors++; $display("FAIL bus_rules: idle addr/data nonzero=%0d, mem_en without hold=%0d, want 0", idle_bus_err, hold_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_controller.md
# dma_controller

Block-transfer DMA engine that copies bytes from one RAM region to another while the CPU controller is parked. It shares the single RAM port with the CPU via an 8085-style HOLD/HLDA handshake: it requests the bus, waits for the CPU to grant it, runs read/write cycles on the RAM, then releases the bus. It is programmed through a small register port and reports completion with a one-cycle pulse.

## Interface
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- BURST_LEN, 4, transfers per bus tenure when burst limiting is compiled in. Must be at least 1.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- cfg_wr  input  1  register write strobe.
- cfg_addr  input  2  register select: 0 = SRC, 1 = DST, 2 = COUNT, 3 = CTRL.
- cfg_wdata  input  DATA_W  write data. CTRL bit0 = start.
- busy  output  1  high from the start until the transfer finishes.
- done  output  1  one-cycle completion pulse.
- hold  output  1  bus request to the CPU controller.
- hlda  input  1  bus grant from the CPU controller.
- mem_en  output  1  RAM enable.
- mem_rw  output  1  1 = write, 0 = read.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data, valid one cycle after the read cycle.

## Operation
- Registers: src_ptr, dst_ptr, count (all ADDR_W wide) and data_reg (DATA_W).
- Writes to SRC, DST and COUNT are accepted only while IDLE. While busy, all cfg writes are ignored, including CTRL.
- FSM states: IDLE, REQ, RD, CAP, WR, REL, FIN.
- IDLE:
  - CTRL write with bit0 = 1 and count != 0 -> REQ.
  - CTRL write with bit0 = 1 and count == 0 -> FIN. No hold is raised.
- REQ: hold = 1. When hlda = 1 -> RD.
- RD: mem_en = 1, mem_rw = 0, mem_addr = src_ptr. -> CAP.
- CAP: data_reg <= mem_rdata; mem_en = 0. -> WR.
- WR:
  - mem_en = 1, mem_rw = 1, mem_addr = dst_ptr, mem_wdata = data_reg.
  - On exit: src_ptr++, dst_ptr++, count--.
  - Next state: count becomes 0 -> FIN; burst limit reached -> REL; otherwise -> RD.
- REL: hold = 0. When hlda = 0 -> REQ.
- FIN: hold = 0. When hlda = 0, pulse done for one cycle and go to IDLE.
- Pointer arithmetic is modulo 2^ADDR_W, so 8'hFF + 1 wraps to 8'h00. Overlapping regions copy in ascending order with no overlap correction.
- hold remains high through RD/CAP/WR for the whole tenure. hlda is sampled only in REQ, REL and FIN; the CPU must not drop hlda while hold = 1.
- busy = (state != IDLE).
- mem_addr and mem_wdata are 0 whenever mem_en = 0.

## Timing
- Reset values: state IDLE; hold, busy, done, mem_en and mem_rw 0; mem_addr and mem_wdata 0; src_ptr, dst_ptr, count and data_reg 0.
- Start write in cycle t -> busy = 1 and hold = 1 in cycle t+1.
- hlda first seen high in cycle h -> RD in cycle h+1.
- Each byte costs 3 cycles (RD, CAP, WR). A block of N bytes needs 3N cycles from the first RD.
- Completion: the last WR is in cycle w. hold = 0 in cycle w+1. done is asserted in the first cycle after hlda is seen low, and busy falls in the same cycle that done is asserted.
- Zero-count start in cycle t: busy = 1 in t+1 (FIN), done = 1 in t+2, provided hlda = 0.
- Reset mid-transfer: next cycle in IDLE with all outputs at reset values. The partial copy is left as-is.

## Configuration
- DMA_BURST_LIMIT_EN defined:
  - A per-tenure counter counts WR cycles.
  - After BURST_LEN transfers, if count != 0, the FSM goes to REL, letting the CPU run at least one fetch before the bus is re-requested.
  - The burst counter clears on every entry to REQ.
- Undefined: the bus is held for the entire block, the REL path is never taken, and BURST_LEN is unused.

## Structure
- Shared package dma_pkg holds:
  - the state enum typedef;
  - register-select constants CFG_SRC, CFG_DST, CFG_CNT, CFG_CTRL;
  - CTRL_START_BIT.
- One sub-module, dma_regs: the cfg-port decode plus the SRC/DST/COUNT registers with load, increment and decrement controls. The FSM and bus outputs stay in dma_controller.

## Test plan
- SRC = 8'h10, DST = 8'h40, COUNT = 3, start, hlda returned 1 cycle after hold -> RAM[40..42] = RAM[10..12], done pulses once, busy spans the transfer, 9 mem cycles.
- COUNT = 0, start -> hold never asserts, done is high exactly 2 cycles after the start write.
- SRC = 8'hFE, DST = 8'h20, COUNT = 4 -> reads 0xFE, 0xFF, 0x00, 0x01 (pointer wrap), writes 0x20 through 0x23.
- Apply reset in the CAP state of the 2nd byte -> next cycle hold = 0, mem_en = 0, busy = 0; only the 1st byte has been written.
- With DMA_BURST_LIMIT_EN, BURST_LEN = 4, COUNT = 10 -> hold drops after the 4th and 8th WR and is re-raised after hlda falls; all 10 bytes are copied.
- While busy, write SRC = 8'h99 and CTRL = 1 -> both are ignored, and the transfer completes using the original pointers.
